// File: rtl/cache_fetch_sequencer_lv1_il_pkg.sv
// Shared L1 instruction-cache definitions: fetch FSM state encoding and LV1 geometry constants.
package cache_fetch_sequencer_lv1_il_pkg;

    localparam int LV1_ADDR_WID    = 32;
    localparam int LV1_ASSOC_WID   = 2;
    localparam int LV1_OFFSET_WID  = 6;   // 64-byte cache blocks
    localparam int LV1_TIMEOUT_CYC = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        HIT_ACK  = 3'd2,
        REQ_LV2  = 3'd3,
        WAIT_LV2 = 3'd4,
        FILL     = 3'd5,
        FILL_ACK = 3'd6
    } fetch_state_e;

endpackage

// File: rtl/cache_fetch_sequencer_lv1_il_timeout_cnt.sv
// Saturating wait counter for LV2 fills; expire flags the last permitted wait cycle.
module fetch_timeout_cnt_lv1 #(
    parameter int LIMIT   = 64,
    parameter int CNT_WID = (LIMIT > 2) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_WID-1:0] SAT_VAL  = CNT_WID'(LIMIT - 1);
    localparam logic [CNT_WID-1:0] LAST_VAL = CNT_WID'(LIMIT - 2);

    logic [CNT_WID-1:0] cnt_q;
    logic [CNT_WID-1:0] cnt_d;

    // next count: clear wins, otherwise count up while enabled and hold at saturation
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != SAT_VAL)) begin
            cnt_d = cnt_q + CNT_WID'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // expiry fires when this cycle's increment brings the count to LIMIT-1
    always_comb begin
        expire = en && !clr && (cnt_q == LAST_VAL);
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fetch_sequencer_lv1_il.sv
// L1 instruction-fetch sequencer: one outstanding lookup, LRU update on hit, LV2 block fill on miss.
module cache_fetch_sequencer_lv1_il
    import cache_fetch_sequencer_lv1_il_pkg::*;
#(
    parameter int ADDR_WID    = LV1_ADDR_WID,
    parameter int ASSOC_WID   = LV1_ASSOC_WID,
    parameter int TIMEOUT_CYC = LV1_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [ADDR_WID-1:0]  addr_bus_cpu_lv1,
    input  logic                 tag_hit,
    input  logic [ASSOC_WID-1:0] hit_way,
    input  logic [ASSOC_WID-1:0] lru_replacement_proc,
    input  logic                 lv2_gnt,
    input  logic                 lv2_data_vld,
    output logic                 tag_lookup,
    output logic [ASSOC_WID-1:0] blk_accessed_main,
    output logic                 lru_update,
    output logic                 lv2_rd_req,
    output logic [ADDR_WID-1:0]  lv2_addr,
    output logic                 fill_en,
    output logic [ASSOC_WID-1:0] fill_way,
    output logic                 cpu_ack,
    output logic                 err_wr,
    output logic                 err_timeout
);

    localparam logic [ADDR_WID-1:0] BLK_MASK =
        {{(ADDR_WID-LV1_OFFSET_WID){1'b1}}, {LV1_OFFSET_WID{1'b0}}};

    fetch_state_e         state_q, state_d;
    logic [ADDR_WID-1:0]  addr_q, addr_d;
    logic [ASSOC_WID-1:0] victim_q, victim_d;
    logic                 err_wr_q, err_wr_d;
    logic                 err_timeout_q, err_timeout_d;

    logic                 lru_update_q, lru_update_d;
    logic                 cpu_ack_q, cpu_ack_d;
    logic                 fill_en_q, fill_en_d;
    logic                 lv2_rd_req_q, lv2_rd_req_d;
    logic [ASSOC_WID-1:0] blk_accessed_main_q, blk_accessed_main_d;
    logic [ASSOC_WID-1:0] fill_way_q, fill_way_d;
    logic [ADDR_WID-1:0]  lv2_addr_q, lv2_addr_d;

    logic                 tag_lookup_s;
    logic                 cnt_clr_s;
    logic                 cnt_en_s;
    logic                 cnt_expire_s;

    fetch_timeout_cnt_lv1 #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_s),
        .en     (cnt_en_s),
        .expire (cnt_expire_s)
    );

    // fetch FSM next-state, address/victim capture and sticky error flags
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        victim_d      = victim_q;
        err_wr_d      = err_wr_q | cpu_wr;
        err_timeout_d = err_timeout_q;
        tag_lookup_s  = 1'b0;
        cnt_clr_s     = 1'b0;
        cnt_en_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_rd && !cpu_wr) begin
                    state_d      = LOOKUP;
                    tag_lookup_s = 1'b1;
                    addr_d       = addr_bus_cpu_lv1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
                if (tag_hit) begin
                    state_d = HIT_ACK;
                end else begin
                    victim_d = lru_replacement_proc;
                    state_d  = REQ_LV2;
                end
            end
            HIT_ACK: begin
                state_d = IDLE;
            end
            REQ_LV2: begin
                if (lv2_gnt) begin
                    cnt_clr_s = 1'b1;
                    // data arriving together with the grant skips the wait state
                    state_d   = lv2_data_vld ? FILL : WAIT_LV2;
                end else begin
                    state_d = REQ_LV2;
                end
            end
            WAIT_LV2: begin
                cnt_en_s = 1'b1;
                if (lv2_data_vld) begin
                    state_d = FILL;
                end else if (cnt_expire_s) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = WAIT_LV2;
                end
            end
            FILL: begin
                state_d = FILL_ACK;
            end
            FILL_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // registered outputs decoded from the state being entered, so they align with that state
    always_comb begin
        lru_update_d        = 1'b0;
        cpu_ack_d           = 1'b0;
        fill_en_d           = 1'b0;
        lv2_rd_req_d        = 1'b0;
        blk_accessed_main_d = '0;
        fill_way_d          = '0;
        lv2_addr_d          = addr_d & BLK_MASK;
        case (state_d)
            HIT_ACK: begin
                lru_update_d        = 1'b1;
                cpu_ack_d           = 1'b1;
                blk_accessed_main_d = hit_way;
            end
            REQ_LV2: begin
                lv2_rd_req_d = 1'b1;
            end
            FILL: begin
                fill_en_d  = 1'b1;
                fill_way_d = victim_d;
            end
            FILL_ACK: begin
                lru_update_d        = 1'b1;
                cpu_ack_d           = 1'b1;
                blk_accessed_main_d = victim_d;
            end
            default: begin
                lru_update_d = 1'b0;
            end
        endcase
    end

    // state, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            addr_q              <= '0;
            victim_q            <= '0;
            err_wr_q            <= 1'b0;
            err_timeout_q       <= 1'b0;
            lru_update_q        <= 1'b0;
            cpu_ack_q           <= 1'b0;
            fill_en_q           <= 1'b0;
            lv2_rd_req_q        <= 1'b0;
            blk_accessed_main_q <= '0;
            fill_way_q          <= '0;
            lv2_addr_q          <= '0;
        end else begin
            state_q             <= state_d;
            addr_q              <= addr_d;
            victim_q            <= victim_d;
            err_wr_q            <= err_wr_d;
            err_timeout_q       <= err_timeout_d;
            lru_update_q        <= lru_update_d;
            cpu_ack_q           <= cpu_ack_d;
            fill_en_q           <= fill_en_d;
            lv2_rd_req_q        <= lv2_rd_req_d;
            blk_accessed_main_q <= blk_accessed_main_d;
            fill_way_q          <= fill_way_d;
            lv2_addr_q          <= lv2_addr_d;
        end
    end

    // tag_lookup must coincide with the accepting IDLE cycle, so it stays combinational
    always_comb begin
        tag_lookup        = tag_lookup_s & ~rst;
        blk_accessed_main = blk_accessed_main_q;
        lru_update        = lru_update_q;
        lv2_rd_req        = lv2_rd_req_q;
        lv2_addr          = lv2_addr_q;
        fill_en           = fill_en_q;
        fill_way          = fill_way_q;
        cpu_ack           = cpu_ack_q;
        err_wr            = err_wr_q;
        err_timeout       = err_timeout_q;
    end

endmodule
